jtopl_eg_seq: RTL

JTOPL_EG_SEQ -- requirements
Module: jtopl_eg_seq

---
 rtl/jtopl_eg_seq_pkg.sv | 6 +
 rtl/jtopl_eg_seq.sv | 68 ++++++
 2 files changed

// File: rtl/jtopl_eg_seq_pkg.sv
// jtopl_eg_seq_pkg: shared slot/channel sizing and stop-FSM encoding for the EG sequencer
package jtopl_eg_seq_pkg;
  localparam int SLOTS_DEF = 18;
  localparam int CH_DEF = SLOTS_DEF / 2;
  typedef enum logic {RUN = 1'b0, STOP = 1'b1} stop_st_t;
endpackage

// File: rtl/jtopl_eg_seq.sv
// jtopl_eg_seq: operator slot sequencer with frame-aligned key-on commit and EG freeze FSM
module jtopl_eg_seq
  import jtopl_eg_seq_pkg::*;
#(
  parameter int SLOTS = SLOTS_DEF,
  parameter int CH = SLOTS / 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cenop,
  input  logic       wr,
  input  logic [4:0] wr_ch,
  input  logic       wr_kon,
  input  logic       stop_req,
  output logic [4:0] slot_I,
  output logic       zero,
  output logic       keyon_I,
  output logic       eg_stop,
  output logic       stop_ack,
  output logic       pend
);
  logic [CH-1:0] kon_pend, kon_act, pend_nxt;
  logic [31:0] act_ext;
  logic wr_ok, wrap;
  stop_st_t st;
  // a write landing on the wrap edge is folded into the committed value
  always_comb begin
    wr_ok = wr && (int'(wr_ch) < CH);
    for (int i = 0; i < CH; i++)
      pend_nxt[i] = (wr_ok && int'(wr_ch) == i) ? wr_kon : kon_pend[i];
    wrap = cenop && (slot_I == 5'(SLOTS - 1));
    act_ext = 32'(kon_act);
  end
  assign zero = slot_I == 5'd0;
  assign keyon_I = act_ext[slot_I >> 1];
  assign pend = |(kon_pend ^ kon_act);
  assign stop_ack = eg_stop;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_I <= 5'd0;
      kon_pend <= '0;
      kon_act <= '0;
    end else begin
      kon_pend <= pend_nxt;
      if (wrap) begin
        slot_I <= 5'd0;
        kon_act <= pend_nxt;
      end else if (cenop) slot_I <= slot_I + 5'd1;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st <= RUN;
      eg_stop <= 1'b0;
    end else if (wrap) begin
      case (st)
        RUN: if (stop_req) begin
          st <= STOP;
          eg_stop <= 1'b1;
        end
        STOP: if (!stop_req) begin
          st <= RUN;
          eg_stop <= 1'b0;
        end
      endcase
    end
  end
endmodule
